// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID and ID/EX pipeline registers, 32x32
// register file with write-through reads, control decode, load-use and
// branch hazard detection, and early beq resolution feeding back into fetch.
module decode_stage #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic [31:0] pc_plus4,
    input  logic        if_valid,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mem_we,
    input  logic [4:0]  mem_dest,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] sl2,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_alu_src,
    output logic        ex_reg_dst,
    output logic [1:0]  ex_alu_op,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h04;

    // IF/ID register
    logic [31:0] id_ins;
    logic [31:0] id_pc4;
    logic        id_valid;

    logic [31:0] rf [NREGS];

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] imm_sx;
    logic [31:0] rs_val, rt_val;

    logic       d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg;
    logic       d_alu_src, d_reg_dst, d_is_beq, d_uses_rt;
    logic [1:0] d_alu_op;

    logic [4:0] ex_dest;
    logic       load_use, branch_haz;

    assign op     = id_ins[31:26];
    assign rs     = id_ins[25:21];
    assign rt     = id_ins[20:16];
    assign rd     = id_ins[15:11];
    assign imm    = id_ins[15:0];
    assign imm_sx = {{16{imm[15]}}, imm};
    assign sl2    = {{14{imm[15]}}, imm, 2'b00};

    // Control decode; unknown opcodes decode to all-zero control
    always_comb begin
        d_reg_write  = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_alu_src    = 1'b0;
        d_reg_dst    = 1'b0;
        d_alu_op     = 2'b00;
        d_is_beq     = 1'b0;
        d_uses_rt    = 1'b0;
        case (op)
            OP_R: begin
                d_reg_write = 1'b1;
                d_reg_dst   = 1'b1;
                d_alu_op    = 2'b10;
                d_uses_rt   = 1'b1;
            end
            OP_LW: begin
                d_reg_write  = 1'b1;
                d_mem_read   = 1'b1;
                d_mem_to_reg = 1'b1;
                d_alu_src    = 1'b1;
            end
            OP_SW: begin
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
                d_uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            OP_BEQ: begin
                d_alu_op  = 2'b01;
                d_is_beq  = 1'b1;
                d_uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Register-file reads with write-back bypass; r0 is hard zero
    always_comb begin
        if (rs == 5'd0)                      rs_val = '0;
        else if (wb_we && wb_addr == rs)     rs_val = wb_data;
        else                                 rs_val = rf[rs];
        if (rt == 5'd0)                      rt_val = '0;
        else if (wb_we && wb_addr == rt)     rt_val = wb_data;
        else                                 rt_val = rf[rt];
    end

    assign ex_dest = ex_reg_dst ? ex_rd : ex_rt;

    // Hazard detection and early branch resolution
    always_comb begin
        load_use = id_valid && ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == rs) || (d_uses_rt && ex_rt == rt));
        branch_haz = id_valid && d_is_beq &&
                     ((ex_valid && ex_reg_write && ex_dest != 5'd0 &&
                       (ex_dest == rs || ex_dest == rt)) ||
                      (mem_we && mem_dest != 5'd0 &&
                       (mem_dest == rs || mem_dest == rt)));
        stall  = load_use || branch_haz;
        pc_src = id_valid && d_is_beq && !stall && (rs_val == rt_val);
    end

    // Register file write; r0 never written so it stays zero after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_we && wb_addr != 5'd0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // IF/ID: hold on stall, squash on taken branch
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_ins   <= '0;
            id_pc4   <= '0;
            id_valid <= 1'b0;
        end else if (stall) begin
            id_ins   <= id_ins;
        end else if (pc_src) begin
            id_ins   <= '0;
            id_valid <= 1'b0;
        end else begin
            id_ins   <= ins;
            id_pc4   <= pc_plus4;
            id_valid <= if_valid;
        end
    end

    // ID/EX: data always follows IF/ID, control is zeroed for bubbles
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_pc4        <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
        end else begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= rs_val;
            ex_rt_data <= rt_val;
            ex_imm     <= imm_sx;
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_rd      <= rd;
            if (stall || !id_valid) begin
                ex_valid      <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_reg_dst    <= 1'b0;
                ex_alu_op     <= 2'b00;
            end else begin
                ex_valid      <= 1'b1;
                ex_reg_write  <= d_reg_write;
                ex_mem_read   <= d_mem_read;
                ex_mem_write  <= d_mem_write;
                ex_mem_to_reg <= d_mem_to_reg;
                ex_alu_src    <= d_alu_src;
                ex_reg_dst    <= d_reg_dst;
                ex_alu_op     <= d_alu_op;
            end
        end
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the MIPS datapath, directly downstream of the fetch stage. It holds the IF/ID and ID/EX pipeline registers and the 32x32 register file, generates control, detects load-use and branch hazards, and resolves `beq` early. The `pc_src` and `sl2` outputs feed back into fetch. `stall` holds the program counter.

## Interface
Parameters:
- `NREGS`, 32: register-file depth. Fixed for MIPS.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-low.
- `ins`, input, 32: instruction from fetch.
- `pc_plus4`, input, 32: PC+4 of `ins`.
- `if_valid`, input, 1: `ins` is meaningful.
- `wb_we`, input, 1: write-back enable.
- `wb_addr`, input, 5: write-back register.
- `wb_data`, input, 32: write-back data.
- `mem_we`, input, 1: EX/MEM instruction writes a register.
- `mem_dest`, input, 5: EX/MEM destination register.
- `stall`, output, 1: hold PC and IF/ID (combinational).
- `pc_src`, output, 1: branch taken (combinational).
- `sl2`, output, 32: sign-extended immediate << 2 of the IF/ID instruction (combinational).
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_alu_src`, `ex_reg_dst`, outputs, 1 each: registered ID/EX control.
- `ex_alu_op`, output, 2: 00 add, 01 sub, 10 funct.
- `ex_pc4`, `ex_rs_data`, `ex_rt_data`, `ex_imm`, outputs, 32 each: registered ID/EX data. `ex_imm` is sign-extended.
- `ex_rs`, `ex_rt`, `ex_rd`, outputs, 5 each: registered register fields.

## Operation
- **Field extraction:** op = ins[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], in MIPS numbering with bit 31 as the MSB.
- **Decode**, control bits in order reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op:
  - R-type, op 0x00: 1,0,0,0,0,1,10.
  - lw, op 0x23: 1,1,0,1,1,0,00.
  - sw, op 0x2B: 0,0,1,0,1,0,00.
  - addi, op 0x08: 1,0,0,0,1,0,00.
  - beq, op 0x04: 0,0,0,0,0,0,01.
  - Any other opcode: all control bits 0. It is passed as valid but has no effect.
- **Register file:**
  - r0 reads 0 and ignores writes.
  - Written on the rising edge when `wb_we` is high and `wb_addr` is nonzero.
  - Reads are write-through: a same-cycle `wb_addr` match returns `wb_data`.
- **ID/EX destination:** dest = rd when reg_dst is 1, else rt.
- **Load-use stall:** `stall` = 1 when ID/EX `ex_valid`, `ex_mem_read`, and `ex_rt` ≠ 0 match the IF/ID rs, or match the IF/ID rt for an R-type, sw, or beq instruction.
- **Branch stall:** for a valid beq in IF/ID, `stall` = 1 when either of these is pending for a nonzero register equal to its rs or rt:
  - an ID/EX write (`ex_reg_write`, with dest as above);
  - an EX/MEM write (`mem_we`, `mem_dest`).
- **Branch resolution:** `pc_src` = id_valid & beq & !stall & (rs_val == rt_val).
- **`sl2`:** `{{14{imm[15]}}, imm, 2'b00}`. It is always driven, even when not valid.
- **Register update priority** at each edge: reset, then stall, then pc_src, then normal.
  - **stall:** IF/ID holds. ID/EX loads a bubble: all control bits 0 and `ex_valid` 0; data fields are don't-care.
  - **pc_src:** IF/ID loads a bubble (id_valid 0), squashing the fetched instruction. ID/EX receives the beq normally.
  - **normal:**
    - IF/ID loads `ins`, `pc_plus4`, `if_valid`.
    - ID/EX loads the decoded IF/ID contents.
    - When id_valid is 0, ID/EX loads a bubble.

## Timing
- **Reset** (`reset` = 0 at a rising edge):
  - IF/ID is cleared: id_valid = 0, instruction = 0.
  - Every `ex_*` output becomes 0.
  - All registers in the file become 0.
  - `stall`, `pc_src`, and `sl2` read 0 from the next cycle on.
  - Reset mid-stall or mid-branch discards all in-flight state.
- **Latency:** an instruction on `ins` at edge N is in IF/ID after N. Its decoded result is on `ex_*` after edge N+1.
- **stall and pc_src:** both are valid within the cycle after an IF/ID update, so fetch samples them at the next edge. `pc_src` is never 1 while `stall` is 1.
- **Write-back vs. read:** a write at edge N is seen by a read in the same cycle before N (bypass) and all later cycles.
- **Stall length:** a load-use stall lasts exactly one cycle, because the bubble clears the ID/EX match. A branch stall repeats until no hazard remains.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles with random inputs → all `ex_*` = 0, `stall` = 0, `pc_src` = 0. Register r5 reads 0 afterwards.
- **Write-back bypass:** write r8 = 0x1234 via WB in the same cycle that `add r9,r8,r8` sits in IF/ID → `ex_rs_data` = `ex_rt_data` = 0x1234. Writing r0 = 0xFFFF leaves r0 reading 0.
- **Load-use:** `lw r2,4(r1)` then `add r3,r2,r4` →
  - one cycle with `stall` = 1;
  - `ex_valid` = 0 after the next edge;
  - the add reaches `ex_*` one edge later with `ex_rs` = 2.
- **Taken beq:** r1 = r2 = 7, `beq r1,r2,-3`, no hazards →
  - `pc_src` = 1 and `sl2` = 0xFFFFFFF4;
  - the following instruction is squashed (`ex_valid` = 0 two edges later).
- **Not-taken beq:** r1 = 7, r2 = 8 → `pc_src` = 0 and no squash.
- **Branch hazard:** `addi r1,r0,5` immediately before `beq r1,r1,...` →
  - `stall` = 1 while the addi is in ID/EX, and again while `mem_we`=1, `mem_dest`=1;
  - then `pc_src` = 1.
